spi_master: RTL and testbench

Single-clock SPI master that drives the `SS_n`/`MOSI` pins of the team's SPI slave and its single-port RAM, and captures the `MISO` read-data byte. It accepts one command per valid/ready handshake and serialises it into a 10-bit frame: 2-bit command plus 8-bit payload, MSB first. For read-data commands it deserialises the 8-bit response after a fixed latency. It sits in the host/test-harness side of the design, one cycle-synchronous hop from the slave (no separate SCLK; both sides run on `clk`).

---
 rtl/spi_pkg.sv | 30 +++
 rtl/spi_master.sv | 170 +++++++++++++++++
 tb/tb_spi_master.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// spi_pkg : command/state encodings and frame widths shared by SPI master/slave
// Rev 1.0
// ----------------------------------------------------------------------------
package spi_pkg;

   localparam int FRAME_W = 10;
   localparam int DATA_W  = 8;
   localparam int ADDR_W  = 8;

   typedef enum logic [1:0] {
      CMD_WR_ADDR = 2'b00,
      CMD_WR_DATA = 2'b01,
      CMD_RD_ADDR = 2'b10,
      CMD_RD_DATA = 2'b11
   } spi_cmd_e;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_SEL       = 3'd1,
      ST_SHIFT_OUT = 3'd2,
      ST_WAIT_RD   = 3'd3,
      ST_SHIFT_IN  = 3'd4,
      ST_END       = 3'd5,
      ST_GAP       = 3'd6
   } spi_mst_state_e;

endpackage
`default_nettype wire

// File: rtl/spi_master.sv
`default_nettype none
// ----------------------------------------------------------------------------
// spi_master : serialises {cmd,payload} frames MSB first, captures rd-data byte
// Rev 1.0
// ----------------------------------------------------------------------------
module spi_master
   import spi_pkg::*;
#(
   parameter int unsigned RD_LAT     = 3,
   parameter int unsigned GAP_CYCLES = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [1:0]        req_cmd,
   input  logic [DATA_W-1:0] req_payload,
   output logic              SS_n,
   output logic              MOSI,
   input  logic              MISO,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_data,
   output logic              busy
);

   localparam logic [4:0] c_shift_out_last = 5'd10;
   localparam logic [4:0] c_shift_in_last  = 5'd7;
   localparam logic [4:0] c_wait_last      = (RD_LAT > 1)     ? 5'(RD_LAT - 2)     : 5'd0;
   localparam logic [4:0] c_gap_last       = (GAP_CYCLES > 1) ? 5'(GAP_CYCLES - 2) : 5'd0;

   spi_mst_state_e      r_state;
   spi_mst_state_e      w_state_nxt;
   logic [4:0]          r_cnt;
   logic [4:0]          w_cnt_nxt;
   logic [FRAME_W-1:0]  r_word;
   logic [DATA_W-1:0]   r_shreg;
   logic [DATA_W-1:0]   w_shreg_nxt;
   logic                r_ss_n;
   logic                r_mosi;
   logic                r_rsp_valid;
   logic [DATA_W-1:0]   r_rsp_data;
   logic                w_accept;
   logic                w_ss_n_nxt;
   logic                w_mosi_nxt;
   logic                w_rsp_fire;
   logic [3:0]          w_bit_idx;

   assign req_ready   = (r_state == ST_IDLE);
   assign busy        = ~req_ready;
   assign w_accept    = req_valid & req_ready;
   assign w_shreg_nxt = {r_shreg[DATA_W-2:0], MISO};
   assign SS_n        = r_ss_n;
   assign MOSI        = r_mosi;
   assign rsp_valid   = r_rsp_valid;
   assign rsp_data    = r_rsp_data;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // END plus GAP span GAP_CYCLES cycles; the IDLE cycle completes the inter-frame gap.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_ss_n_nxt  = 1'b1;
      w_mosi_nxt  = 1'b0;
      w_rsp_fire  = 1'b0;
      w_bit_idx   = 4'd9;
      case (r_state)
         ST_IDLE: begin
            if (req_valid) begin
               w_state_nxt = ST_SEL;
               w_cnt_nxt   = '0;
            end
         end
         ST_SEL: begin
            w_state_nxt = ST_SHIFT_OUT;
            w_cnt_nxt   = '0;
         end
         ST_SHIFT_OUT: begin
            if (r_cnt == c_shift_out_last) begin
               w_cnt_nxt = '0;
               if (r_word[FRAME_W-1 -: 2] != CMD_RD_DATA) begin
                  w_state_nxt = ST_END;
               end else if (RD_LAT == 1) begin
                  w_state_nxt = ST_SHIFT_IN;
               end else begin
                  w_state_nxt = ST_WAIT_RD;
               end
            end else begin
               w_cnt_nxt = r_cnt + 5'd1;
            end
         end
         ST_WAIT_RD: begin
            if (r_cnt == c_wait_last) begin
               w_state_nxt = ST_SHIFT_IN;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt = r_cnt + 5'd1;
            end
         end
         ST_SHIFT_IN: begin
            if (r_cnt == c_shift_in_last) begin
               w_state_nxt = ST_END;
               w_cnt_nxt   = '0;
               w_rsp_fire  = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt + 5'd1;
            end
         end
         ST_END: begin
            w_state_nxt = (GAP_CYCLES > 1) ? ST_GAP : ST_IDLE;
            w_cnt_nxt   = '0;
         end
         ST_GAP: begin
            if (r_cnt == c_gap_last) begin
               w_state_nxt = ST_IDLE;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt = r_cnt + 5'd1;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
         end
      endcase

      w_ss_n_nxt = (w_state_nxt == ST_IDLE) || (w_state_nxt == ST_END) || (w_state_nxt == ST_GAP);
      // First shift cycle repeats the direction bit, then word[9]..word[0].
      if (w_cnt_nxt != 5'd0) begin
         w_bit_idx = 4'(5'd10 - w_cnt_nxt);
      end
      if (w_state_nxt == ST_SHIFT_OUT) begin
         w_mosi_nxt = r_word[w_bit_idx];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_word      <= '0;
         r_shreg     <= '0;
         r_ss_n      <= 1'b1;
         r_mosi      <= 1'b0;
         r_rsp_valid <= 1'b0;
         r_rsp_data  <= '0;
      end else begin
         if (w_accept) begin
            r_word <= {req_cmd, req_payload};
         end
         if (r_state == ST_SHIFT_IN) begin
            r_shreg <= w_shreg_nxt;
         end
         r_ss_n      <= w_ss_n_nxt;
         r_mosi      <= w_mosi_nxt;
         r_rsp_valid <= w_rsp_fire;
         if (w_rsp_fire) begin
            r_rsp_data <= w_shreg_nxt;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_spi_master.sv
`default_nettype none
// tb_spi_master : directed frames checked every cycle against a frame-offset model,
// plus hand-computed literal expectations.
module tb_spi_master;
   import spi_pkg::*;

   localparam int RD_LAT     = 3;
   localparam int GAP_CYCLES = 1;
   localparam int LOGN       = 4096;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       req_valid;
   logic       req_ready;
   logic [1:0] req_cmd;
   logic [7:0] req_payload;
   logic       SS_n;
   logic       MOSI;
   logic       MISO;
   logic       rsp_valid;
   logic [7:0] rsp_data;
   logic       busy;

   always #5 clk = ~clk;

   spi_master #(.RD_LAT(RD_LAT), .GAP_CYCLES(GAP_CYCLES)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_cmd    (req_cmd),
      .req_payload(req_payload),
      .SS_n       (SS_n),
      .MOSI       (MOSI),
      .MISO       (MISO),
      .rsp_valid  (rsp_valid),
      .rsp_data   (rsp_data),
      .busy       (busy)
   );

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   bit m_started = 1'b0;

   // frame model: position m_k counts cycles from S0 of the current frame
   logic       m_active = 1'b0;
   int         m_k = 0;
   logic [9:0] m_word = '0;
   logic       m_rd = 1'b0;
   logic [7:0] m_cap = '0;
   logic [7:0] m_rsp = '0;
   logic       m_ss = 1'b1, m_mosi = 1'b0, m_vld = 1'b0, m_ready = 1'b1;

   logic       ss_log  [LOGN];
   logic       mosi_log[LOGN];
   logic       vld_log [LOGN];
   logic [7:0] rsp_log [LOGN];

   logic [7:0] lb_mem [256];
   logic [7:0] lb_addr;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   always @(posedge clk) begin
      int len;
      int idx;
      cyc++;
      if (!rst_n) begin
         m_started = 1'b1;
         m_active  = 1'b0;
         m_k       = 0;
         m_rsp     = '0;
         m_ss      = 1'b1;
         m_mosi    = 1'b0;
         m_vld     = 1'b0;
         m_ready   = 1'b1;
      end else if (m_started) begin
         if (m_active) begin
            if (m_rd && m_k >= 11 + RD_LAT && m_k <= 18 + RD_LAT) m_cap = {m_cap[6:0], MISO};
            m_k++;
         end else if (req_valid === 1'b1) begin
            m_active = 1'b1;
            m_k      = 0;
            m_word   = {req_cmd, req_payload};
            m_rd     = (req_cmd == 2'b11);
            m_cap    = '0;
         end
         m_vld = 1'b0;
         if (m_active) begin
            len    = m_rd ? 19 + RD_LAT : 12;
            m_ss   = (m_k < len) ? 1'b0 : 1'b1;
            idx    = (m_k == 1) ? 9 : 11 - m_k;
            m_mosi = (m_k >= 1 && m_k <= 11) ? m_word[idx] : 1'b0;
            if (m_rd && m_k == len) begin
               m_vld = 1'b1;
               m_rsp = m_cap;
            end
            if (m_k >= len + GAP_CYCLES) m_active = 1'b0;
         end
         m_ready = !m_active;
      end
   end

   always @(negedge clk) begin
      if (m_started) begin
         if (cyc < LOGN) begin
            ss_log[cyc]   = SS_n;
            mosi_log[cyc] = MOSI;
            vld_log[cyc]  = rsp_valid;
            rsp_log[cyc]  = rsp_data;
         end
         chk("ss_n",      32'(SS_n),      32'(m_ss));
         chk("mosi",      32'(MOSI),      32'(m_mosi));
         chk("rsp_valid", 32'(rsp_valid), 32'(m_vld));
         chk("rsp_data",  32'(rsp_data),  32'(m_rsp));
         chk("req_ready", 32'(req_ready), 32'(m_ready));
         chk("busy",      32'(busy),      32'(!m_ready));
      end
   end

   function automatic logic [10:0] mosi_vec(input int s1);
      logic [10:0] v = '0;
      for (int i = 0; i < 11; i++) v = {v[9:0], mosi_log[s1 + i]};
      return v;
   endfunction

   function automatic logic [12:0] ss_vec(input int s0);
      logic [12:0] v = '0;
      for (int i = 0; i < 13; i++) v = {v[11:0], ss_log[s0 + i]};
      return v;
   endfunction

   function automatic int count_ones_vld(input int from, input int to);
      int n = 0;
      for (int i = from; i <= to; i++) if (vld_log[i] === 1'b1) n++;
      return n;
   endfunction

   // called on a negedge; returns on the negedge of S0, a = accept cycle
   task automatic send(input logic [1:0] c, input logic [7:0] p, output int a);
      int t = 0;
      req_valid = 1'b1;
      req_cmd = c;
      req_payload = p;
      while (req_ready !== 1'b1 && t < 200) begin
         @(negedge clk);
         t++;
      end
      checks++;
      if (t >= 200) begin
         errors++;
         $display("FAIL accept_timeout: got req_ready %b expected 1 within 200 cycles", req_ready);
      end
      a = cyc;
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   task automatic rd_frame(input logic [7:0] b, output int a);
      MISO = 1'b1;
      send(CMD_RD_DATA, 8'h00, a);
      repeat (11 + RD_LAT) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         MISO = b[7 - i];
         @(negedge clk);
      end
      MISO = 1'b0;
   endtask

   task automatic lb_op(input logic [1:0] c, input logic [7:0] p);
      int a;
      case (c)
         CMD_WR_ADDR: lb_addr = p;
         CMD_WR_DATA: lb_mem[lb_addr] = p;
         CMD_RD_ADDR: lb_addr = p;
         default: ;
      endcase
      if (c == CMD_RD_DATA) rd_frame(lb_mem[lb_addr], a);
      else send(c, p, a);
   endtask

   initial begin
      #200000;
      errors++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      int a, a1, a2, n;
      rst_n = 1'b0;
      req_valid = 1'b0;
      req_cmd = 2'b00;
      req_payload = 8'h00;
      MISO = 1'b0;
      for (int i = 0; i < 256; i++) lb_mem[i] = 8'h00;
      lb_addr = 8'h00;
      repeat (3) @(negedge clk);
      chk("rst_ss_n",      32'(SS_n),      32'd1);
      chk("rst_mosi",      32'(MOSI),      32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rsp_data",  32'(rsp_data),  32'd0);
      chk("rst_req_ready", 32'(req_ready), 32'd1);
      chk("rst_busy",      32'(busy),      32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // WR_ADDR 0x5A
      send(CMD_WR_ADDR, 8'h5A, a);
      repeat (16) @(negedge clk);
      chk("wr_mosi_bits", 32'(mosi_vec(a + 2)), 32'(11'b00001011010));
      chk("wr_ss_window", 32'(ss_vec(a + 1)),   32'(13'b0000000000001));
      chk("wr_no_rsp",    32'(count_ones_vld(a + 1, a + 15)), 32'd0);

      // RD_DATA with MISO carrying 0xA5
      rd_frame(8'hA5, a);
      repeat (10) @(negedge clk);
      chk("rd_valid_s22",  32'(vld_log[a + 23]), 32'd1);
      chk("rd_valid_once", 32'(count_ones_vld(a + 1, a + 32)), 32'd1);
      chk("rd_data_held",  32'(rsp_log[a + 32]), 32'hA5);

      // loopback through a slave/RAM model
      lb_op(CMD_WR_ADDR, 8'h10);
      lb_op(CMD_WR_DATA, 8'hC3);
      lb_op(CMD_RD_ADDR, 8'h10);
      lb_op(CMD_RD_DATA, 8'h00);
      repeat (6) @(negedge clk);
      chk("loopback_data", 32'(rsp_data), 32'hC3);

      // req_valid held across two WR_DATA requests
      req_valid = 1'b1;
      req_cmd = CMD_WR_DATA;
      req_payload = 8'h01;
      n = 0;
      while (req_ready !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      a1 = cyc;
      @(negedge clk);
      req_payload = 8'h02;
      n = 0;
      while (req_ready !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      a2 = cyc;
      @(negedge clk);
      req_valid = 1'b0;
      repeat (16) @(negedge clk);
      chk("b2b_accept_gap", 32'(a2 - a1), 32'(13 + GAP_CYCLES));
      n = 0;
      for (int i = a1 + 13; i < a1 + 30; i++) begin
         if (ss_log[i] !== 1'b1) break;
         n++;
      end
      chk("b2b_ss_high_cycles", 32'(n), 32'd2);
      chk("b2b_second_bits", 32'(mosi_vec(a2 + 2)), 32'(11'b00100000010));

      // request pulsed mid-frame must be ignored
      send(CMD_WR_ADDR, 8'h5A, a);
      repeat (3) @(negedge clk);
      req_valid = 1'b1;
      req_cmd = CMD_WR_DATA;
      req_payload = 8'hFF;
      chk("mid_ready", 32'(req_ready), 32'd0);
      @(negedge clk);
      req_valid = 1'b0;
      req_payload = 8'h00;
      repeat (22) @(negedge clk);
      chk("mid_mosi_bits", 32'(mosi_vec(a + 2)), 32'(11'b00001011010));
      n = 0;
      for (int i = a + 13; i <= a + 22; i++) if (ss_log[i] === 1'b1) n++;
      chk("mid_no_accept", 32'(n), 32'd10);

      // reset at S6 of a rd-data frame
      MISO = 1'b1;
      send(CMD_RD_DATA, 8'h00, a);
      repeat (6) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      chk("mrst_ss_n",      32'(SS_n),      32'd1);
      chk("mrst_mosi",      32'(MOSI),      32'd0);
      chk("mrst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("mrst_req_ready", 32'(req_ready), 32'd1);
      chk("mrst_rsp_data",  32'(rsp_data),  32'd0);
      rst_n = 1'b1;
      MISO = 1'b0;
      send(CMD_WR_ADDR, 8'h33, a);
      repeat (16) @(negedge clk);
      chk("post_rst_bits", 32'(mosi_vec(a + 2)), 32'(11'b00000110011));
      chk("post_rst_ss",   32'(ss_vec(a + 1)),   32'(13'b0000000000001));

      repeat (4) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
